// File: rtl/led_seq_pkg.sv
// Shared types and frame helpers for the N-lamp LED sequencer.
// Frames are computed on a wide vector and sliced by the user.
package led_seq_pkg;

    localparam int MAX_LEDS = 64;

    typedef logic [MAX_LEDS-1:0] frame_t;

    typedef enum logic [1:0] {
        MODE_CALM   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_e;

    function automatic frame_t all_on(int n);
        frame_t f;
        f = '0;
        for (int i = 0; i < MAX_LEDS; i++)
            if (i < n) f[i] = 1'b1;
        return f;
    endfunction

    function automatic frame_t outer_on(int n);
        frame_t f;
        f = '0;
        f[0] = 1'b1;
        f[n-1] = 1'b1;
        return f;
    endfunction

    function automatic frame_t initial_frame(mode_e m, int n);
        frame_t f;
        f = '0;
        unique case (m)
            MODE_CALM:   f = all_on(n) & ~outer_on(n);
            MODE_LEFT:   f[0] = 1'b1;
            MODE_RIGHT:  f[n-1] = 1'b1;
            MODE_HAZARD: f = all_on(n);
        endcase
        return f;
    endfunction

    function automatic frame_t next_frame(mode_e m, frame_t led, int n);
        frame_t f;
        frame_t inner;
        f = '0;
        inner = all_on(n) & ~outer_on(n);
        unique case (m)
            MODE_CALM:   f = (led == inner) ? outer_on(n) : inner;
            MODE_LEFT: begin
                f[0] = led[n-1];
                for (int i = 1; i < MAX_LEDS; i++)
                    if (i < n) f[i] = led[i-1];
            end
            MODE_RIGHT: begin
                f[n-1] = led[0];
                for (int i = 0; i < MAX_LEDS - 1; i++)
                    if (i < n - 1) f[i] = led[i+1];
            end
            MODE_HAZARD: f = (led == all_on(n)) ? '0 : all_on(n);
        endcase
        return f;
    endfunction

endpackage

// File: rtl/led_sequencer_sync.sv
// Multi-flop synchronizer for a slow asynchronous bus.
// Synchronous reset clears every stage to zero.
module sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++)
                stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++)
                stg[i] <= stg[i-1];
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/led_sequencer.sv
// N-lamp animated LED bar: calm, left/right sweep and hazard flash,
// with a step prescaler, freeze enable and synchronized mode input.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS      = 3,
    parameter int TICK_DIV    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              enable,
    output logic [N_LEDS-1:0] led,
    output logic              step_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    if (N_LEDS < 3 || N_LEDS > MAX_LEDS) begin : g_bad_n
        $error("led_sequencer: N_LEDS out of range");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("led_sequencer: TICK_DIV must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("led_sequencer: SYNC_STAGES must be >= 2");
    end

    logic [1:0]    mode_q;
    mode_e         mode_s;
    mode_e         active;
    logic [PW-1:0] presc;
    frame_t        calm_w;
    frame_t        init_w;
    frame_t        next_w;

    sync_bus #(
        .WIDTH (2),
        .STAGES(SYNC_STAGES)
    ) u_mode_sync (
        .clk  (clk),
        .reset(reset),
        .d    (mode),
        .q    (mode_q)
    );

    assign mode_s = mode_e'(mode_q);

    always_comb begin
        calm_w = initial_frame(MODE_CALM, N_LEDS);
        init_w = initial_frame(mode_s, N_LEDS);
        next_w = next_frame(active, frame_t'(led), N_LEDS);
    end

    // Mode change outranks the prescaler tick and ignores enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            active     <= MODE_CALM;
            presc      <= '0;
            led        <= calm_w[N_LEDS-1:0];
            step_pulse <= 1'b0;
        end else if (mode_s != active) begin
            active     <= mode_s;
            presc      <= '0;
            led        <= init_w[N_LEDS-1:0];
            step_pulse <= 1'b0;
        end else if (enable) begin
            if (presc == LAST) begin
                presc      <= '0;
                led        <= next_w[N_LEDS-1:0];
                step_pulse <= 1'b1;
            end else begin
                presc      <= presc + PW'(1);
                step_pulse <= 1'b0;
            end
        end else begin
            step_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: default config and N_LEDS=5/TICK_DIV=1,
// directed steps plus random traffic against a step-count model.
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       enable;
    logic [2:0] led0;
    logic [4:0] led1;
    logic       sp0;
    logic       sp1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_sequencer u0 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .enable    (enable),
        .led       (led0),
        .step_pulse(sp0)
    );

    led_sequencer #(
        .N_LEDS  (5),
        .TICK_DIV(1)
    ) u1 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .enable    (enable),
        .led       (led1),
        .step_pulse(sp1)
    );

    // Model: frame = f(mode, steps taken since the mode began).
    int nl [2] = '{3, 5};
    int dv [2] = '{4, 1};
    int act [2];
    int cnt [2];
    int k [2];
    logic pul [2];
    int s0, s1;

    function automatic logic [7:0] exp_led(int m, int kk, int n);
        logic [7:0] all, outer;
        all   = 8'((1 << n) - 1);
        outer = 8'(1 | (1 << (n - 1)));
        case (m)
            0:       return (kk % 2 == 1) ? outer : (all & ~outer);
            1:       return 8'(1 << (kk % n));
            2:       return 8'(1 << (n - 1 - (kk % n)));
            default: return (kk % 2 == 1) ? 8'h00 : all;
        endcase
    endfunction

    always @(posedge clk) begin
        int ms;
        ms = s1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                act[i] = 0; cnt[i] = 0; k[i] = 0; pul[i] = 1'b0;
            end else if (ms != act[i]) begin
                act[i] = ms; cnt[i] = 0; k[i] = 0; pul[i] = 1'b0;
            end else if (enable) begin
                if (cnt[i] == dv[i] - 1) begin
                    cnt[i] = 0; k[i] = k[i] + 1; pul[i] = 1'b1;
                end else begin
                    cnt[i] = cnt[i] + 1; pul[i] = 1'b0;
                end
            end else begin
                pul[i] = 1'b0;
            end
        end
        if (reset) begin
            s1 = 0; s0 = 0;
        end else begin
            s1 = s0; s0 = int'(mode);
        end
    end

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(int n = 1);
        logic [7:0] e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            e = exp_led(act[0], k[0], 3);
            chk("m_led0", 8'(led0), e);
            chk("m_sp0", 8'(sp0), 8'(pul[0]));
            e = exp_led(act[1], k[1], 5);
            chk("m_led1", 8'(led1), e);
            chk("m_sp1", 8'(sp1), 8'(pul[1]));
        end
    endtask

    task automatic wait_pulse0();
        int b;
        b = 0;
        while (sp0 !== 1'b1 && b < 20) begin
            tick();
            b++;
        end
        chk("pulse_bound", 8'(sp0), 8'd1);
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; enable = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("rst_led0", 8'(led0), 8'b010);
        chk("rst_sp0", 8'(sp0), 8'd0);
        chk("rst_led1", 8'(led1), 8'b01110);
        tick(4);
        chk("calm_101", 8'(led0), 8'b101);
        chk("calm_sp", 8'(sp0), 8'd1);
        tick(4);
        chk("calm_010", 8'(led0), 8'b010);

        mode = 2'b01;
        tick(3);
        chk("left_init", 8'(led0), 8'b001);
        chk("left_init_sp", 8'(sp0), 8'd0);
        tick(4);
        chk("left_010", 8'(led0), 8'b010);
        chk("left_sp", 8'(sp0), 8'd1);
        tick(2);
        enable = 1'b0;
        tick(10);
        chk("frz_led", 8'(led0), 8'b010);
        enable = 1'b1;
        tick(1);
        chk("unfrz_hold", 8'(led0), 8'b010);
        tick(1);
        chk("unfrz_100", 8'(led0), 8'b100);
        chk("unfrz_sp", 8'(sp0), 8'd1);
        tick(4);
        chk("left_wrap", 8'(led0), 8'b001);

        mode = 2'b10;
        tick(3);
        chk("right_init", 8'(led0), 8'b100);
        tick(12);
        mode = 2'b11;
        tick(3);
        chk("haz_init", 8'(led0), 8'b111);
        tick(4);
        chk("haz_000", 8'(led0), 8'b000);
        tick(4);
        chk("haz_111", 8'(led0), 8'b111);

        // Mode change lands on the same edge as the prescaler wrap.
        wait_pulse0();
        tick(1);
        mode = 2'b01;
        tick(3);
        chk("coinc_led", 8'(led0), 8'b001);
        chk("coinc_sp", 8'(sp0), 8'd0);
        tick(3);
        chk("coinc_hold", 8'(led0), 8'b001);
        tick(1);
        chk("coinc_next", 8'(led0), 8'b010);

        mode = 2'b10;
        tick(9);
        reset = 1'b1;
        tick(1);
        chk("midrst_led", 8'(led0), 8'b010);
        chk("midrst_sp", 8'(sp0), 8'd0);
        chk("midrst_led1", 8'(led1), 8'b01110);
        reset = 1'b0;
        mode = 2'b00;
        tick(3);

        mode = 2'b01;
        tick(3);
        chk("n5_left", 8'(led1), 8'b00001);
        tick(4);
        chk("n5_walk", 8'(led1), 8'b10000);
        tick(1);
        chk("n5_wrap", 8'(led1), 8'b00001);

        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 99) == 0);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
